// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD sequential multiplier.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam int BCD_MAX = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_digit_adder.sv
// One decimal digit of a ripple BCD adder with +6 correction.
import bcd_pkg::*;

module bcd_digit_adder (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout
);

    logic [DIGIT_W:0] raw;
    logic [DIGIT_W:0] fixed;

    assign raw   = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    assign cout  = raw > (DIGIT_W+1)'(BCD_MAX);
    assign fixed = raw + (DIGIT_W+1)'(6);
    assign sum   = cout ? fixed[DIGIT_W-1:0] : raw[DIGIT_W-1:0];

endmodule

// File: rtl/bcd_seq_multiplier.sv
// Digit-serial BCD multiplier: shift-by-ten then repeated BCD addition.
import bcd_pkg::*;

module bcd_seq_multiplier #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [8*DIGITS-1:0]   product
);

    localparam int AW = 8 * DIGITS;

    state_t              state;
    logic [4*DIGITS-1:0] xr;
    logic [4*DIGITS-1:0] yr;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_sum;
    logic [AW-1:0]       xe;
    logic [3:0]          cnt;
    logic [1:0]          idx;
    logic                err_pend;
    logic [2*DIGITS:0]   carry;
    logic                unused_carry;

    function automatic logic all_bcd(input logic [4*DIGITS-1:0] v);
        all_bcd = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'(BCD_MAX))
                all_bcd = 1'b0;
    endfunction

    assign xe           = {{(4*DIGITS){1'b0}}, xr};
    assign carry[0]     = 1'b0;
    assign unused_carry = carry[2*DIGITS];

    for (genvar g = 0; g < 2*DIGITS; g++) begin : g_add
        bcd_digit_adder u_dig (
            .a    (acc[4*g +: 4]),
            .b    (xe[4*g +: 4]),
            .cin  (carry[g]),
            .sum  (acc_sum[4*g +: 4]),
            .cout (carry[g+1])
        );
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            xr       <= '0;
            yr       <= '0;
            acc      <= '0;
            cnt      <= '0;
            idx      <= '0;
            err_pend <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            product  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (all_bcd(x) && all_bcd(y)) begin
                            xr    <= x;
                            yr    <= y;
                            acc   <= '0;
                            idx   <= 2'(DIGITS - 1);
                            state <= SHIFT;
                        end else begin
                            err_pend <= 1'b1;
                            product  <= '0;
                            state    <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    acc   <= {acc[AW-5:0], 4'b0000};
                    cnt   <= yr[4*int'(idx) +: 4];
                    state <= ADD;
                end
                ADD: begin
                    if (cnt != 4'd0) begin
                        acc <= acc_sum;
                        cnt <= cnt - 4'd1;
                    end else if (idx != 2'd0) begin
                        idx   <= idx - 2'd1;
                        state <= SHIFT;
                    end else begin
                        done    <= 1'b1;
                        product <= acc;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // an illegal operand reports one cycle after entering DONE
                    if (err_pend) begin
                        done     <= 1'b1;
                        err      <= 1'b1;
                        err_pend <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
